// File: rtl/nibble_sort_pkg.sv
// nibble_sort_pkg
//   Shared types and constants for the nibble sort engine.
//   NIB_W     : element width handled by the compare cell
//   MAX_DEPTH : largest supported burst length
//   state_t   : engine FSM states (load -> sort -> drain)
package nibble_sort_pkg;

   localparam int unsigned NIB_W     = 4;
   localparam int unsigned MAX_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SORT,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/nibble_sort_engine_cmp_swap.sv
// nibble_cmp_swap
//   Combinational magnitude compare-and-swap decision for two nibbles.
//   a, b     : operands, a sits at the lower buffer index
//   desc     : 1 = descending order requested
//   a_gt_b   : a > b
//   a_lt_b   : a < b
//   eq       : a == b
//   do_swap  : operands are out of order for the requested direction;
//              equal operands never swap so the sort stays stable
module nibble_cmp_swap
   import nibble_sort_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             desc,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             eq,
   output logic             do_swap
);

   always_comb begin
      a_gt_b  = (a > b);
      a_lt_b  = (a < b);
      eq      = (a == b);
      do_swap = desc ? a_lt_b : a_gt_b;
   end

endmodule

// File: rtl/nibble_sort_engine.sv
// nibble_sort_engine
//   Buffers a burst of up to DEPTH nibbles, bubble-sorts it in place using a
//   single shared compare-and-swap cell (one compare per clock), then streams
//   the sorted burst out.
//   Optional build macro: SORT_STATS_EN adds the swap_cnt output and counter.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   desc                : sort direction, captured with the first element
//   in_valid/in_ready   : input handshake (ready only while loading)
//   in_data, in_last    : element and end-of-burst marker
//   out_valid/out_ready : output handshake (valid only while draining)
//   out_data, out_last  : sorted element and end-of-burst marker
//   busy                : sorting or draining
//   swap_cnt            : swaps performed for the current burst (stats build)
module nibble_sort_engine
   import nibble_sort_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 4
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         desc,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
`ifdef SORT_STATS_EN
   ,
   output logic [7:0]   swap_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned IW = $clog2(DEPTH);

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   i_q, i_d;
   logic [CW-1:0]   pass_q, pass_d;
   logic [CW-1:0]   rd_q, rd_d;
   logic            swapped_q, swapped_d;
   logic            desc_q, desc_d;
   logic [W-1:0]    mem_q [DEPTH];

   logic [IW-1:0]   idx_a, idx_b;
   logic            cmp_gt, cmp_lt, cmp_eq, cmp_swap;
   logic            unused_cmp;
   logic [CW-1:0]   cnt_inc;
   logic            pass_end;
   logic            load_fire;
   logic            swap_fire;

   // Compare positions i and i+1; i never exceeds DEPTH-2 so i+1 fits IW bits.
   always_comb begin
      idx_a      = i_q[IW-1:0];
      idx_b      = idx_a + IW'(1);
      unused_cmp = cmp_gt ^ cmp_lt ^ cmp_eq;
   end

   nibble_cmp_swap u_cmp (
      .a       (mem_q[idx_a]),
      .b       (mem_q[idx_b]),
      .desc    (desc_q),
      .a_gt_b  (cmp_gt),
      .a_lt_b  (cmp_lt),
      .eq      (cmp_eq),
      .do_swap (cmp_swap)
   );

   // State register and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         count_q   <= '0;
         i_q       <= '0;
         pass_q    <= '0;
         rd_q      <= '0;
         swapped_q <= 1'b0;
         desc_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         i_q       <= i_d;
         pass_q    <= pass_d;
         rd_q      <= rd_d;
         swapped_q <= swapped_d;
         desc_q    <= desc_d;
      end
   end

   // Buffer storage; contents are don't-care until loaded, so no reset.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem_q[count_q[IW-1:0]] <= in_data;
      end else if (swap_fire) begin
         mem_q[idx_a] <= mem_q[idx_b];
         mem_q[idx_b] <= mem_q[idx_a];
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      i_d       = i_q;
      pass_d    = pass_q;
      rd_d      = rd_q;
      swapped_d = swapped_q;
      desc_d    = desc_q;
      cnt_inc   = count_q + CW'(1);
      // Last compare of a pass sits at n-2-pass; n >= 2 whenever this is used.
      pass_end  = (i_q == (count_q - CW'(2) - pass_q));
      load_fire = (state_q == ST_LOAD) && in_valid;
      swap_fire = (state_q == ST_SORT) && cmp_swap;

      unique case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               count_d = cnt_inc;
               if (count_q == '0) desc_d = desc;
               if (in_last || (cnt_inc == CW'(DEPTH))) begin
                  if (cnt_inc == CW'(1)) begin
                     state_d = ST_DRAIN;
                     rd_d    = '0;
                  end else begin
                     state_d   = ST_SORT;
                     i_d       = '0;
                     pass_d    = '0;
                     swapped_d = 1'b0;
                  end
               end
            end
         end
         ST_SORT: begin
            i_d       = i_q + CW'(1);
            swapped_d = swapped_q | cmp_swap;
            if (pass_end) begin
               if (!(swapped_q || cmp_swap) || (pass_q == (count_q - CW'(2)))) begin
                  state_d = ST_DRAIN;
                  rd_d    = '0;
               end else begin
                  pass_d    = pass_q + CW'(1);
                  i_d       = '0;
                  swapped_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               rd_d = rd_q + CW'(1);
               if (rd_q == (count_q - CW'(1))) begin
                  state_d = ST_LOAD;
                  count_d = '0;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      out_valid = (state_q == ST_DRAIN);
      busy      = (state_q != ST_LOAD);
      out_data  = (state_q == ST_DRAIN) ? mem_q[rd_q[IW-1:0]] : '0;
      out_last  = (state_q == ST_DRAIN) && (rd_q == (count_q - CW'(1)));
   end

`ifdef SORT_STATS_EN
   logic [7:0] swap_cnt_q;

   // Cleared as the final element drains, held through DRAIN for readout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swap_cnt_q <= '0;
      end else if ((state_q == ST_DRAIN) && out_ready && (rd_q == (count_q - CW'(1)))) begin
         swap_cnt_q <= '0;
      end else if (swap_fire && (swap_cnt_q != 8'hFF)) begin
         swap_cnt_q <= swap_cnt_q + 8'd1;
      end
   end

   always_comb swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_sort_engine.sv
// tb_nibble_sort_engine
//   Directed bench for nibble_sort_engine (DEPTH=8). Bursts are packed as
//   hex words with element 0 in the least significant nibble.
module tb_nibble_sort_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       desc;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_last;
   logic       busy;
`ifdef SORT_STATS_EN
   logic [7:0] swap_cnt;
`endif

   int errs   = 0;
   int checks = 0;
   bit poke_busy = 1'b0;

   always #5 clk = ~clk;

   nibble_sort_engine #(.DEPTH(8), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .desc      (desc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
`ifdef SORT_STATS_EN
      ,
      .swap_cnt  (swap_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "/in_ready"},  32'(in_ready),  32'd1);
      check({tag, "/out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "/out_last"},  32'(out_last),  32'd0);
      check({tag, "/out_data"},  32'(out_data),  32'd0);
      check({tag, "/busy"},      32'(busy),      32'd0);
`ifdef SORT_STATS_EN
      check({tag, "/swap_cnt"},  32'(swap_cnt),  32'd0);
`endif
   endtask

   // Loads n elements, measures SORT cycles, drains and checks the order.
   task automatic run_burst(input string name, input logic [63:0] vin, input int n,
                            input bit d, input bit with_last, input logic [63:0] vexp,
                            input int exp_sort, input int exp_swaps, input bit rnd);
      int sc;
      int idx;
      int guard;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = vin[4*k +: 4];
         in_last  = with_last && (k == n-1);
         desc     = d;
         check({name, "/load_ready"}, 32'(in_ready), 32'd1);
      end
      @(negedge clk);
      in_valid = poke_busy;
      in_last  = 1'b0;
      in_data  = 4'hF;
      desc     = ~d;
      sc = 0;
      while (!out_valid && sc < 200) begin
         check({name, "/sort_busy"}, 32'(busy), 32'd1);
         if (poke_busy) check({name, "/sort_no_ready"}, 32'(in_ready), 32'd0);
         sc++;
         @(negedge clk);
      end
      check({name, "/sort_cycles"}, 32'(sc), 32'(exp_sort));
`ifdef SORT_STATS_EN
      check({name, "/swap_cnt"}, 32'(swap_cnt), 32'(exp_swaps));
`else
      if (exp_swaps < 0) $display("note: negative swap expectation in %s", name);
`endif
      idx   = 0;
      guard = 0;
      while (idx < n && guard < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid  = poke_busy && !(out_ready && idx == n-1);
         check({name, "/out_valid"}, 32'(out_valid), 32'd1);
         check({name, "/out_data"},  32'(out_data),  32'(vexp[4*idx +: 4]));
         check({name, "/out_last"},  32'(out_last),  32'(idx == n-1));
         check({name, "/drain_no_ready"}, 32'(in_ready), 32'd0);
         if (out_ready) idx++;
         guard++;
         @(negedge clk);
      end
      check({name, "/drained"}, 32'(idx), 32'(n));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({name, "/back_ready"}, 32'(in_ready),  32'd1);
      check({name, "/back_idle"},  32'(busy),      32'd0);
      check({name, "/back_nvld"},  32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      desc      = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      // 5,3,9,0 ascending / descending
      run_burst("asc4",  64'h0935, 4, 1'b0, 1'b1, 64'h9530, 6, 4, 1'b0);
      run_burst("desc4", 64'h0935, 4, 1'b1, 1'b1, 64'h0359, 6, 2, 1'b0);
      // presorted full burst ends on the 8th element without in_last
      run_burst("full8", 64'h87654321, 8, 1'b0, 1'b0, 64'h87654321, 7, 0, 1'b0);
      // single element, then duplicates 4,4,2
      run_burst("single", 64'h7, 1, 1'b0, 1'b1, 64'h7, 0, 0, 1'b0);
      run_burst("dups",   64'h244, 3, 1'b0, 1'b1, 64'h442, 3, 2, 1'b0);
      // 6,1,8,3,3 descending with stalling consumer and input poked while busy
      poke_busy = 1'b1;
      run_burst("stall", 64'h33816, 5, 1'b1, 1'b1, 64'h13368, 9, 4, 1'b1);
      poke_busy = 1'b0;
      // input presented while busy must not have leaked into the next burst
      run_burst("after_poke", 64'h52, 2, 1'b0, 1'b1, 64'h52, 1, 0, 1'b0);

      // reset in the middle of a worst-case sort of 8..1
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 4'(8 - k);
         in_last  = 1'b0;
         desc     = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_sort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_idle("mid_sort_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_burst("post_rst", 64'h1F, 2, 1'b0, 1'b1, 64'hF1, 1, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
